ipsxe_floating_point_result_buf_v1_0: RTL
=========================================

IPSXE_FLOATING_POINT_RESULT_BUF_V1_0 -- requirements
Module: ipsxe_floating_point_result_buf_v1_0

Interface
REQ-001 Parameter DATA_WIDTH, default 32, result tdata width.
REQ-002 Parameter TUSER_RESULT_WIDTH, default 1, result tuser width, matching the tuser stage output.
REQ-003 Parameter DEPTH, default 16, buffer entries; power of two, range 4..64.
REQ-004 Port i_aclk  input  1  clock; all logic on rising edge.
REQ-005 Port i_areset_n  input  1  reset, synchronous, active-low.
REQ-006 Port i_aclken  input  1  clock enable; low freezes all state.
REQ-007 Port o_issue_ready  output  1  high when the pipeline may launch one new operation.
REQ-008 Port i_issue  input  1  pipeline launched an operation this cycle.
REQ-009 Port i_res_valid  input  1  pipeline result present; no backpressure possible.
REQ-010 Port i_res_tdata  input  DATA_WIDTH  result data.
REQ-011 Port i_res_tuser  input  TUSER_RESULT_WIDTH  result tuser from the tuser stage.
REQ-012 Port i_res_tlast  input  1  result tlast.
REQ-013 Ports o_axi4s_result_tvalid/tdata/tuser/tlast  output  1/DATA_WIDTH/TUSER_RESULT_WIDTH/1  AXI4-Stream master.
REQ-014 Port i_axi4s_result_tready  input  1  downstream ready.
REQ-015 Port o_overflow  output  1  sticky error: result arrived with no free entry.

Function
REQ-016 All state updates SHALL occur only on cycles with i_aclken=1; outputs hold otherwise.
REQ-017 Storage SHALL be a circular buffer of DEPTH entries {tlast,tuser,tdata} with wr_ptr, rd_ptr (log2 DEPTH bits, wrap DEPTH-1 -> 0) and count (0..DEPTH).
REQ-018 o_axi4s_result_tvalid SHALL equal (count != 0); tdata/tuser/tlast SHALL be the entry at rd_ptr.
REQ-019 Pop SHALL occur when tvalid and tready are both 1; rd_ptr increments.
REQ-020 Push SHALL occur when i_res_valid=1 and (count < DEPTH or pop this cycle); wr_ptr increments.
REQ-021 A result written on edge k SHALL be visible on the outputs immediately after edge k (1-cycle latency, empty to tvalid).
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH.
REQ-023 i_res_valid=1 with count=DEPTH and no pop SHALL drop the result, leave pointers unchanged, and set o_overflow until reset.
REQ-024 An inflight counter (0..DEPTH) SHALL increment on accepted issue (i_issue & o_issue_ready) and decrement on i_res_valid; both together leave it unchanged; decrement saturates at 0.
REQ-025 o_issue_ready SHALL be registered, equal to (count_next + inflight_next < DEPTH).
REQ-026 i_issue while o_issue_ready=0 SHALL be ignored.
REQ-027 Output data SHALL remain stable while tvalid=1 and tready=0 (AXI4-Stream rule).
REQ-028 tvalid SHALL not depend combinationally on tready.

Reset
REQ-029 On i_areset_n=0 at an edge (regardless of i_aclken): pointers, count, inflight, o_overflow = 0; tvalid=0; o_issue_ready=1; storage contents not reset.
REQ-030 Reset mid-transfer SHALL discard all buffered and in-flight results; results arriving in the first cycle after reset SHALL be accepted normally.

Structure
REQ-031 Pointer width function (clog2) and entry-packing offsets SHALL reside in the shared floating-point package.
REQ-032 One sub-module SHALL be used: ipsxe_floating_point_credit_cnt_v1_0 (inflight counter and issue_ready); storage and pointers stay in the top.

Verification
REQ-033 Reset, then single result tdata=0x3F800000, tuser=1, tready=1 -> tvalid high exactly one cycle later with that data, count back to 0.
REQ-034 tready=0, push 16 results (DEPTH=16) -> o_issue_ready=0 after in-flight+count reaches 16; 17th forced result sets o_overflow=1, entries 0..15 intact.
REQ-035 Full buffer, push and pop same cycle -> count stays 16, no overflow, order preserved across wr_ptr wrap 15->0.
REQ-036 Random tready (50%) with 1000 issued ops, PIPE latency 8 -> output sequence equals input sequence, o_overflow=0.
REQ-037 i_aclken=0 for 5 cycles with tvalid=1 and tready=1 -> no pop, outputs stable; resumes on aclken=1.
REQ-038 Assert reset with 6 entries and 3 in flight -> next cycle tvalid=0, o_issue_ready=1, o_overflow=0.

Source files
------------

// File: rtl/ipsxe_floating_point_result_buf_v1_0_pkg.sv
// Shared floating-point helpers: pointer sizing, result-entry packing offsets
// and the push/pop operation encoding used by the result buffer.
package ipsxe_floating_point_result_buf_v1_0_pkg;

    // Push/pop combination seen by the buffer in one cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        BUF_IDLE = 2'b00,
        BUF_POP  = 2'b01,
        BUF_PUSH = 2'b10,
        BUF_BOTH = 2'b11
    } buf_op_e;

    // Smallest r with 2**r >= value (pointer width for a power-of-two depth)
    function automatic int fp_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Entries are packed as {tlast, tuser, tdata} with tdata in the low bits
    function automatic int fp_tuser_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int fp_tlast_bit(input int data_width, input int tuser_width);
        return data_width + tuser_width;
    endfunction

    function automatic int fp_entry_width(input int data_width, input int tuser_width);
        return data_width + tuser_width + 1;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_result_buf_v1_0_credit_cnt.sv
// Tracks operations launched into the pipeline whose results have not yet
// arrived, and grants issue only while buffered + in-flight results fit.
module ipsxe_floating_point_credit_cnt_v1_0
    import ipsxe_floating_point_result_buf_v1_0_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = fp_clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             aclken,
    input  logic             issue,
    input  logic             res_valid,
    input  logic [CNT_W-1:0] count_next,
    output logic             issue_ready
);

    localparam logic [CNT_W-1:0]   FULL_INFLIGHT = CNT_W'(DEPTH);
    localparam logic [CNT_W+1:0]   CREDIT_LIMIT  = (CNT_W + 2)'(DEPTH);

    logic [CNT_W-1:0] inflight_reg;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W+1:0] credit_sum;
    logic             accept;

    // An issue only counts when it was actually granted
    assign accept = issue & issue_ready;

    // Next in-flight count: up on accepted issue, down on result, saturating both ways
    always_comb begin
        inflight_next = inflight_reg;
        if (accept && !res_valid) begin
            if (inflight_reg != FULL_INFLIGHT) begin
                inflight_next = inflight_reg + CNT_W'(1);
            end
        end else if (!accept && res_valid) begin
            if (inflight_reg != '0) begin
                inflight_next = inflight_reg - CNT_W'(1);
            end
        end
    end

    assign credit_sum = (CNT_W + 2)'(count_next) + (CNT_W + 2)'(inflight_next);

    // Register the in-flight count and the issue grant for the next cycle
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            inflight_reg <= '0;
            issue_ready  <= 1'b1;
        end else if (aclken) begin
            inflight_reg <= inflight_next;
            issue_ready  <= (credit_sum < CREDIT_LIMIT);
        end
    end

endmodule

// File: rtl/ipsxe_floating_point_result_buf_v1_0.sv
// Result buffer between a non-stallable floating-point pipeline and an
// AXI4-Stream master. Results land in a circular buffer; issue credit keeps
// the pipeline from launching more work than the buffer can absorb.
module ipsxe_floating_point_result_buf_v1_0
    import ipsxe_floating_point_result_buf_v1_0_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int TUSER_RESULT_WIDTH = 1,
    parameter int DEPTH              = 16
) (
    input  logic                          i_aclk,
    input  logic                          i_areset_n,
    input  logic                          i_aclken,
    output logic                          o_issue_ready,
    input  logic                          i_issue,
    input  logic                          i_res_valid,
    input  logic [DATA_WIDTH-1:0]         i_res_tdata,
    input  logic [TUSER_RESULT_WIDTH-1:0] i_res_tuser,
    input  logic                          i_res_tlast,
    output logic                          o_axi4s_result_tvalid,
    output logic [DATA_WIDTH-1:0]         o_axi4s_result_tdata,
    output logic [TUSER_RESULT_WIDTH-1:0] o_axi4s_result_tuser,
    output logic                          o_axi4s_result_tlast,
    input  logic                          i_axi4s_result_tready,
    output logic                          o_overflow
);

    localparam int PTR_W     = fp_clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int ENTRY_W   = fp_entry_width(DATA_WIDTH, TUSER_RESULT_WIDTH);
    localparam int TUSER_LSB = fp_tuser_lsb(DATA_WIDTH);
    localparam int TLAST_BIT = fp_tlast_bit(DATA_WIDTH, TUSER_RESULT_WIDTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               overflow_reg;
    logic               pop;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    buf_op_e            op;

    // A pop frees the head slot in the same cycle, so a full buffer still accepts
    assign pop  = o_axi4s_result_tvalid & i_axi4s_result_tready;
    assign push = i_res_valid & ((count_reg != FULL_COUNT) | pop);
    assign drop = i_res_valid & ~push;
    assign op   = buf_op_e'({push, pop});

    // Pack the incoming result as {tlast, tuser, tdata}
    always_comb begin
        wr_entry                                      = '0;
        wr_entry[DATA_WIDTH-1:0]                      = i_res_tdata;
        wr_entry[TUSER_LSB +: TUSER_RESULT_WIDTH]     = i_res_tuser;
        wr_entry[TLAST_BIT]                           = i_res_tlast;
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count_reg;
        case (op)
            BUF_PUSH: count_next = count_reg + CNT_W'(1);
            BUF_POP:  count_next = count_reg - CNT_W'(1);
            default:  count_next = count_reg;
        endcase
    end

    // Storage write; contents are deliberately left out of reset
    always_ff @(posedge i_aclk) begin
        if (i_areset_n && i_aclken && push) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    // Pointers, occupancy and the sticky overflow flag
    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (i_aclken) begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Head entry drives the stream; it cannot change until it is popped
    assign rd_entry              = mem[rd_ptr_reg];
    assign o_axi4s_result_tvalid = (count_reg != '0);
    assign o_axi4s_result_tdata  = rd_entry[DATA_WIDTH-1:0];
    assign o_axi4s_result_tuser  = rd_entry[TUSER_LSB +: TUSER_RESULT_WIDTH];
    assign o_axi4s_result_tlast  = rd_entry[TLAST_BIT];
    assign o_overflow            = overflow_reg;

    ipsxe_floating_point_credit_cnt_v1_0 #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_credit_cnt (
        .clk         (i_aclk),
        .areset_n    (i_areset_n),
        .aclken      (i_aclken),
        .issue       (i_issue),
        .res_valid   (i_res_valid),
        .count_next  (count_next),
        .issue_ready (o_issue_ready)
    );

endmodule
